// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Instruction-fetch stage with a circular prefetch queue feeding ID.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

`ifndef JUMP
`define JUMP 5'b11000
`endif

module fetch_queue #(
  parameter int          ADDR_W  = 8,
  parameter int          IR_W    = 16,
  parameter int          DEPTH   = 2,
  parameter logic [4:0]  JUMP_OP = `JUMP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     state,
  input  logic                     jump,
  input  logic [ADDR_W-1:0]        jump_target,
  input  logic                     stall,
  input  logic [IR_W-1:0]          i_datain,
  output logic [ADDR_W-1:0]        i_addr,
  output logic [IR_W-1:0]          id_ir,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [IR_W-1:0]    r_q_ir [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [ADDR_W-1:0]  r_pc;
  logic [IR_W-1:0]    r_id_ir;
  logic [ADDR_W-1:0]  r_id_pc;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_early;
  logic               w_push;
  logic [IR_W-1:0]    w_head_ir;
  logic [ADDR_W-1:0]  w_head_pc;

  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == c_full);
    w_head_ir = r_q_ir[r_rd_ptr];
    w_head_pc = r_q_pc[r_rd_ptr];
    w_pop     = !jump && !stall && !w_empty;
    w_early   = w_pop && (w_head_ir[IR_W-1 -: 5] == JUMP_OP);
    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    w_push    = !jump && !w_early && (!w_full || w_pop);
  end

  // Queue storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (state && w_push) begin
      r_q_ir[r_wr_ptr] <= i_datain;
      r_q_pc[r_wr_ptr] <= r_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_id_ir  <= '0;
      r_id_pc  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (state) begin
      if (jump) begin
        r_pc     <= jump_target;
        r_id_ir  <= '0;
        r_id_pc  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_id_ir  <= w_head_ir;
          r_id_pc  <= w_head_pc;
        end else if (!stall) begin
          r_id_ir  <= '0;
          r_id_pc  <= '0;
        end
        if (w_early) begin
          // Jump resolved at issue: discard everything fetched past it.
          r_pc     <= w_head_ir[ADDR_W-1:0];
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            r_pc     <= r_pc + ADDR_W'(1);
          end
          r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
      end
    end
  end

  assign i_addr  = r_pc;
  assign id_ir   = r_id_ir;
  assign id_pc   = r_id_pc;
  assign q_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_queue                                                       |
// | Directed self-checking bench for fetch_queue (DEPTH=2).              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module tb_fetch_queue;

  localparam logic [4:0] c_jump_op = 5'b11111;

  logic        clock;
  logic        reset;
  logic        state;
  logic        jump;
  logic [7:0]  jump_target;
  logic        stall;
  logic [15:0] i_datain;
  logic [7:0]  i_addr;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic [1:0]  q_count;

  logic [15:0] mem [256];
  int          n_checks;
  int          n_errors;

  fetch_queue #(
    .ADDR_W  (8),
    .IR_W    (16),
    .DEPTH   (2),
    .JUMP_OP (c_jump_op)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .jump        (jump),
    .jump_target (jump_target),
    .stall       (stall),
    .i_datain    (i_datain),
    .i_addr      (i_addr),
    .id_ir       (id_ir),
    .id_pc       (id_pc),
    .q_count     (q_count)
  );

  assign i_datain = mem[i_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    state       = 1'b0;
    jump        = 1'b0;
    jump_target = 8'h00;
    stall       = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    tick(); tick();
    check("rst_id_ir",  32'(id_ir),   32'h0);
    check("rst_id_pc",  32'(id_pc),   32'h0);
    check("rst_count",  32'(q_count), 32'h0);
    check("rst_pc",     32'(i_addr),  32'h0);

    // Stream: edge 1 is a NOP, then mem[0], mem[1], ...
    reset = 1'b1;
    state = 1'b1;
    tick();
    check("e1_id_ir",  32'(id_ir),   32'h0);
    check("e1_count",  32'(q_count), 32'h1);
    check("e1_pc",     32'(i_addr),  32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("str_id_ir", 32'(id_ir),   32'h1000 + 32'(k));
      check("str_id_pc", 32'(id_pc),   32'(k));
      check("str_count", 32'(q_count), 32'h1);
    end

    // Stall fill: queue holds mem[4]; one more fetch then pc freezes.
    stall = 1'b1;
    tick();
    check("stl1_count", 32'(q_count), 32'h2);
    check("stl1_pc",    32'(i_addr),  32'h6);
    tick(); tick(); tick();
    check("stl4_count", 32'(q_count), 32'h2);
    check("stl4_pc",    32'(i_addr),  32'h6);
    check("stl4_id_ir", 32'(id_ir),   32'h1003);
    check("stl4_id_pc", 32'(id_pc),   32'h3);
    stall = 1'b0;
    for (int k = 4; k < 7; k++) begin
      tick();
      check("rel_id_ir", 32'(id_ir),   32'h1000 + 32'(k));
      check("rel_id_pc", 32'(id_pc),   32'(k));
      check("rel_count", 32'(q_count), 32'h2);
    end

    // Redirect beats stall with a full queue.
    jump        = 1'b1;
    jump_target = 8'h40;
    stall       = 1'b1;
    tick();
    check("rd_count", 32'(q_count), 32'h0);
    check("rd_id_ir", 32'(id_ir),   32'h0);
    check("rd_id_pc", 32'(id_pc),   32'h0);
    check("rd_pc",    32'(i_addr),  32'h40);
    jump  = 1'b0;
    stall = 1'b0;
    tick();
    check("rd1_id_ir", 32'(id_ir),  32'h0);
    check("rd1_pc",    32'(i_addr), 32'h41);
    tick();
    check("rd2_id_ir", 32'(id_ir),  32'h1040);
    check("rd2_id_pc", 32'(id_pc),  32'h40);

    // Idle and wrap: get mem[FE] queued with pc = FF, then freeze.
    jump        = 1'b1;
    jump_target = 8'hFE;
    tick();
    jump = 1'b0;
    tick();
    check("pre_idle_pc",    32'(i_addr),  32'hFF);
    check("pre_idle_count", 32'(q_count), 32'h1);
    state       = 1'b0;
    jump        = 1'b1;
    jump_target = 8'h10;
    tick(); tick(); tick();
    check("idle_pc",    32'(i_addr),  32'hFF);
    check("idle_count", 32'(q_count), 32'h1);
    check("idle_id_ir", 32'(id_ir),   32'h0);
    state = 1'b1;
    jump  = 1'b0;
    tick();
    check("wr1_id_ir", 32'(id_ir),  32'h10FE);
    check("wr1_pc",    32'(i_addr), 32'h00);
    tick();
    check("wr2_id_ir", 32'(id_ir),  32'h10FF);
    check("wr2_id_pc", 32'(id_pc),  32'hFF);
    tick();
    check("wr3_id_ir", 32'(id_ir),  32'h1000);
    check("wr3_id_pc", 32'(id_pc),  32'h00);

    // Async reset mid-stall with a full queue, between clock edges.
    stall = 1'b1;
    tick();
    check("ar_pre_count", 32'(q_count), 32'h2);
    #1 reset = 1'b0;
    #1;
    check("ar_id_ir", 32'(id_ir),   32'h0);
    check("ar_id_pc", 32'(id_pc),   32'h0);
    check("ar_count", 32'(q_count), 32'h0);
    check("ar_pc",    32'(i_addr),  32'h0);

    // Early jump at mem[3] to 0x20; mem[4] must never issue.
    mem[3] = {c_jump_op, 3'b000, 8'h20};
    mem[4] = 16'hDEAD;
    tick();
    reset = 1'b1;
    stall = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ej_pre_id_ir", 32'(id_ir), 32'h1000 + 32'(k));
    end
    tick();
    check("ej_id_ir", 32'(id_ir),   32'hF820);
    check("ej_id_pc", 32'(id_pc),   32'h3);
    check("ej_pc",    32'(i_addr),  32'h20);
    check("ej_count", 32'(q_count), 32'h0);
    tick();
    check("ej_nop_id_ir", 32'(id_ir), 32'h0);
    tick();
    check("ej_tgt_id_ir", 32'(id_ir), 32'h1020);
    check("ej_tgt_id_pc", 32'(id_pc), 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
